// File: rtl/sme_scheduler.sv
// sme_scheduler: round-robin two-requester front end for the string-matching engine.
// Build option: define SME_SCHED_TIMEOUT_EN to bound WAIT at TIMEOUT cycles.
module sme_scheduler #(
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   output logic       gnt0,
   output logic       gnt1,
   input  logic [7:0] chardata0,
   input  logic [7:0] chardata1,
   input  logic       isstring0,
   input  logic       isstring1,
   input  logic       ispattern0,
   input  logic       ispattern1,
   output logic [7:0] sme_chardata,
   output logic       sme_isstring,
   output logic       sme_ispattern,
   input  logic       sme_valid,
   input  logic       sme_match,
   input  logic [4:0] sme_match_index,
   output logic       resp_valid,
   output logic       resp_id,
   output logic       resp_match,
   output logic [4:0] resp_index,
   output logic       resp_err,
   output logic       busy
);

`ifdef SME_SCHED_TIMEOUT_EN
   localparam bit TmoEn = 1'b1;
`else
   localparam bit TmoEn = 1'b0;
`endif
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic            ptr_q, ptr_d;
   logic            id_q, id_d;
   logic            err_q, err_d;
   logic [5:0]      scnt_q, scnt_d;
   logic [3:0]      pcnt_q, pcnt_d;
   logic [7:0]      chr_q, chr_d;
   logic            sstr_q, sstr_d;
   logic            spat_q, spat_d;
   logic            match_q, match_d;
   logic [4:0]      idx_q, idx_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;

   logic            g_s, g_p, tmo;
   logic [7:0]      g_c;

   assign g_s = id_q ? isstring1  : isstring0;
   assign g_p = id_q ? ispattern1 : ispattern0;
   assign g_c = id_q ? chardata1  : chardata0;
   assign tmo = TmoEn && (tcnt_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
         scnt_q  <= '0;
         pcnt_q  <= '0;
         chr_q   <= '0;
         sstr_q  <= 1'b0;
         spat_q  <= 1'b0;
         match_q <= 1'b0;
         idx_q   <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         err_q   <= err_d;
         scnt_q  <= scnt_d;
         pcnt_q  <= pcnt_d;
         chr_q   <= chr_d;
         sstr_q  <= sstr_d;
         spat_q  <= spat_d;
         match_q <= match_d;
         idx_q   <= idx_d;
         tcnt_q  <= tcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      err_d   = err_q;
      scnt_d  = scnt_q;
      pcnt_d  = pcnt_q;
      chr_d   = '0;
      sstr_d  = 1'b0;
      spat_d  = 1'b0;
      match_d = match_q;
      idx_d   = idx_q;
      tcnt_d  = '0;
      unique case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               id_d    = ptr_q ? req1 : !req0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            // A non-pattern cycle after the first pattern char closes the job
            if (pcnt_q != 4'd0 && !g_p) begin
               state_d = WAIT;
               if (g_s) err_d = 1'b1;
            end else if (g_s && g_p) begin
               err_d = 1'b1;
            end else if (g_s) begin
               if (scnt_q == 6'd32) begin
                  err_d = 1'b1;
               end else begin
                  scnt_d = scnt_q + 6'd1;
                  sstr_d = 1'b1;
                  chr_d  = g_c;
               end
            end else if (g_p) begin
               if (pcnt_q == 4'd8) begin
                  err_d = 1'b1;
               end else begin
                  pcnt_d = pcnt_q + 4'd1;
                  spat_d = 1'b1;
                  chr_d  = g_c;
               end
            end
         end
         WAIT: begin
            tcnt_d = tcnt_q + 1'b1;
            if (sme_valid) begin
               match_d = sme_match;
               idx_d   = sme_match_index;
               state_d = RESP;
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            ptr_d   = !id_q;
            err_d   = 1'b0;
            scnt_d  = '0;
            pcnt_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q != IDLE);
      gnt0       = busy && !id_q;
      gnt1       = busy && id_q;
      resp_valid = 1'b0;
      resp_id    = 1'b0;
      resp_match = 1'b0;
      resp_index = '0;
      resp_err   = 1'b0;
      if (state_q == RESP) begin
         resp_valid = 1'b1;
         resp_id    = id_q;
         resp_match = match_q && !err_q;
         resp_index = err_q ? 5'd0 : idx_q;
         resp_err   = err_q;
      end
   end

   assign sme_chardata  = chr_q;
   assign sme_isstring  = sstr_q;
   assign sme_ispattern = spat_q;

endmodule
